// File: rtl/seq_divider.sv
// Multi-cycle non-restoring integer divider, signed/unsigned, with divide-by-zero flag.
// result = {quotient, remainder}; done pulses for one cycle when the result is ready.
module seq_divider #(
  parameter int BITS            = 32,
  parameter int STEPS_PER_CYCLE = 1
) (
  input  logic                clk,
  input  logic                clr,
  input  logic                start,
  input  logic                is_signed,
  input  logic [BITS-1:0]     dividend,
  input  logic [BITS-1:0]     divisor,
  output logic                busy,
  output logic                done,
  output logic                div_by_zero,
  output logic [2*BITS-1:0]   result
);

  localparam int N  = BITS / STEPS_PER_CYCLE;
  localparam int CW = $clog2(N) + 1;

  // state  | meaning
  // IDLE   | waiting for start; operands latched on the accepting edge
  // RUN    | N iterations, STEPS_PER_CYCLE quotient bits per cycle
  // FIX    | remainder correction and sign fix-up, result written
  // ZERO   | divide-by-zero result written, flag set
  // DONE   | done pulse, back to IDLE
  typedef enum logic [2:0] {S_IDLE, S_RUN, S_FIX, S_ZERO, S_DONE} state_t;

  state_t            r_state;
  state_t            w_state_nx;
  logic [CW-1:0]     r_cnt;
  logic [BITS:0]     r_rem;
  logic [BITS-1:0]   r_quo;
  logic [BITS-1:0]   r_dvs;
  logic              r_neg_q;
  logic              r_neg_r;
  logic              r_dz;
  logic [2*BITS-1:0] r_result;

  logic              w_div_zero;
  logic              w_a_neg;
  logic              w_b_neg;
  logic [BITS-1:0]   w_a_mag;
  logic [BITS-1:0]   w_b_mag;
  logic [BITS:0]     w_dvs_ext;
  logic [BITS:0]     w_rem_nx;
  logic [BITS-1:0]   w_quo_nx;
  logic [BITS:0]     w_sh;
  logic [BITS:0]     w_rem_fix;
  logic [BITS-1:0]   w_r_mag;
  logic [BITS-1:0]   w_r_out;
  logic [BITS-1:0]   w_q_out;

  assign w_div_zero = (divisor == '0);
  assign w_a_neg    = is_signed & dividend[BITS-1];
  assign w_b_neg    = is_signed & divisor[BITS-1];
  assign w_a_mag    = w_a_neg ? (~dividend + 1'b1) : dividend;
  assign w_b_mag    = w_b_neg ? (~divisor + 1'b1) : divisor;
  assign w_dvs_ext  = {1'b0, r_dvs};

  // Partial remainder arithmetic is modulo 2^(BITS+1); the true value always lies in [-d, d).
  always_comb begin
    w_rem_nx = r_rem;
    w_quo_nx = r_quo;
    w_sh     = '0;
    for (int i = 0; i < STEPS_PER_CYCLE; i++) begin
      w_sh = {w_rem_nx[BITS-1:0], w_quo_nx[BITS-1]};
      if (w_rem_nx[BITS])
        w_rem_nx = w_sh + w_dvs_ext;
      else
        w_rem_nx = w_sh - w_dvs_ext;
      w_quo_nx = {w_quo_nx[BITS-2:0], ~w_rem_nx[BITS]};
    end
  end

  assign w_rem_fix = r_rem[BITS] ? (r_rem + w_dvs_ext) : r_rem;
  assign w_r_mag   = w_rem_fix[BITS-1:0];
  assign w_r_out   = r_neg_r ? (~w_r_mag + 1'b1) : w_r_mag;
  assign w_q_out   = r_neg_q ? (~r_quo + 1'b1) : r_quo;

  always_ff @(posedge clk) begin
    if (clr)
      r_state <= S_IDLE;
    else
      r_state <= w_state_nx;
  end

  always_comb begin
    w_state_nx = r_state;
    case (r_state)
      S_IDLE:  if (start) w_state_nx = w_div_zero ? S_ZERO : S_RUN;
      S_RUN:   if (r_cnt == '0) w_state_nx = S_FIX;
      S_FIX:   w_state_nx = S_DONE;
      S_ZERO:  w_state_nx = S_DONE;
      S_DONE:  w_state_nx = S_IDLE;
      default: w_state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      r_cnt    <= '0;
      r_rem    <= '0;
      r_quo    <= '0;
      r_dvs    <= '0;
      r_neg_q  <= 1'b0;
      r_neg_r  <= 1'b0;
      r_dz     <= 1'b0;
      r_result <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_dz    <= 1'b0;
            r_cnt   <= CW'(N - 1);
            r_rem   <= '0;
            r_neg_q <= w_a_neg ^ w_b_neg;
            r_neg_r <= w_a_neg;
            r_dvs   <= w_b_mag;
            // ZERO returns the raw dividend, so keep it unconverted in that case
            r_quo   <= w_div_zero ? dividend : w_a_mag;
          end
        end
        S_RUN: begin
          r_rem <= w_rem_nx;
          r_quo <= w_quo_nx;
          r_cnt <= r_cnt - 1'b1;
        end
        S_FIX:  r_result <= {w_q_out, w_r_out};
        S_ZERO: begin
          r_result <= {{BITS{1'b1}}, r_quo};
          r_dz     <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign busy        = (r_state != S_IDLE);
  assign done        = (r_state == S_DONE);
  assign div_by_zero = r_dz;
  assign result      = r_result;

endmodule

// File: tb/tb_seq_divider.sv
// Bench for seq_divider: directed cases plus a random sweep on two instances
// (1 and 4 quotient bits per cycle), checked through an expected-result queue.
module tb_seq_divider;

  logic clk = 1'b0;
  logic clr;
  always #5 clk = ~clk;

  logic        st0, sg0, busy0, done0, dz0;
  logic [31:0] a0, b0;
  logic [63:0] res0;
  logic        st4, sg4, busy4, done4, dz4;
  logic [31:0] a4, b4;
  logic [63:0] res4;

  seq_divider #(.BITS(32), .STEPS_PER_CYCLE(1)) u_div1 (
    .clk(clk), .clr(clr), .start(st0), .is_signed(sg0), .dividend(a0), .divisor(b0),
    .busy(busy0), .done(done0), .div_by_zero(dz0), .result(res0));

  seq_divider #(.BITS(32), .STEPS_PER_CYCLE(4)) u_div4 (
    .clk(clk), .clr(clr), .start(st4), .is_signed(sg4), .dividend(a4), .divisor(b4),
    .busy(busy4), .done(done4), .div_by_zero(dz4), .result(res4));

  typedef struct {
    logic [63:0] res;
    logic        dz;
    int          edge_n;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %h, expected %h", tag, obs, expv);
    end
  endtask

  function automatic logic [63:0] model(input logic sg, input logic [31:0] a, input logic [31:0] b,
                                        output logic dz);
    longint sa, sbv, q, r;
    logic [31:0] uq, ur;
    dz = 1'b0;
    if (b == 32'd0) begin
      dz = 1'b1;
      return {32'hFFFF_FFFF, a};
    end
    if (sg) begin
      sa  = longint'($signed(a));
      sbv = longint'($signed(b));
      q   = sa / sbv;
      r   = sa % sbv;
      return {q[31:0], r[31:0]};
    end
    uq = a / b;
    ur = a % b;
    return {uq, ur};
  endfunction

  task automatic set_in(input bit sel, input logic st, input logic sg,
                        input logic [31:0] a, input logic [31:0] b);
    if (sel) begin st4 = st; sg4 = sg; a4 = a; b4 = b; end
    else     begin st0 = st; sg0 = sg; a0 = a; b0 = b; end
  endtask

  task automatic get_out(input bit sel, output logic bz, output logic dn, output logic dz,
                         output logic [63:0] rs);
    bz = sel ? busy4 : busy0;
    dn = sel ? done4 : done0;
    dz = sel ? dz4   : dz0;
    rs = sel ? res4  : res0;
  endtask

  task automatic do_op(input bit sel, input logic sg, input logic [31:0] a, input logic [31:0] b,
                       input bit repulse, input string tag);
    exp_t        e;
    logic        edz, bz, dn, dz;
    logic [63:0] rs;
    logic [31:0] q, r, inv;
    int          lat;
    bit          seen;
    e.res    = model(sg, a, b, edz);
    e.dz     = edz;
    e.edge_n = (b == 32'd0) ? 2 : (32 / (sel ? 4 : 1) + 2);
    sb.push_back(e);

    @(negedge clk);
    set_in(sel, 1'b1, sg, a, b);
    @(negedge clk);
    set_in(sel, 1'b0, ~sg, ~a, b + 32'd3);
    get_out(sel, bz, dn, dz, rs);
    chk({tag, " busy_after_start"}, 64'(bz), 64'd1);
    chk({tag, " dz_cleared"}, 64'(dz), 64'd0);

    lat  = 0;
    seen = 1'b0;
    while (!seen && lat < 100) begin
      @(negedge clk);
      lat++;
      get_out(sel, bz, dn, dz, rs);
      if (dn) seen = 1'b1;
      else if (repulse && lat == 5) set_in(sel, 1'b1, 1'b1, 32'd99, 32'd0);
      else set_in(sel, 1'b0, sg, a, b);
    end
    chk({tag, " done_seen"}, 64'(seen), 64'd1);

    e = sb.pop_front();
    chk({tag, " latency"}, 64'(lat + 1), 64'(e.edge_n));
    chk({tag, " result"}, rs, e.res);
    chk({tag, " div_by_zero"}, 64'(dz), 64'(e.dz));
    if (b != 32'd0) begin
      q   = rs[63:32];
      r   = rs[31:0];
      inv = q * b + r;
      chk({tag, " invariant"}, 64'(inv), 64'(a));
    end

    @(negedge clk);
    get_out(sel, bz, dn, dz, rs);
    chk({tag, " done_pulse"}, 64'(dn), 64'd0);
    chk({tag, " idle"}, 64'(bz), 64'd0);
    chk({tag, " held"}, rs, e.res);
  endtask

  initial begin
    logic        bz, dn, dz, seen;
    logic [63:0] rs;
    logic [31:0] ra, rb;
    logic        rsg;

    clr = 1'b1;
    set_in(1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
    set_in(1'b1, 1'b0, 1'b0, 32'd0, 32'd0);
    repeat (3) @(negedge clk);
    clr = 1'b0;
    get_out(1'b0, bz, dn, dz, rs);
    chk("reset busy", 64'(bz), 64'd0);
    chk("reset done", 64'(dn), 64'd0);
    chk("reset dz", 64'(dz), 64'd0);
    chk("reset result", rs, 64'd0);
    get_out(1'b1, bz, dn, dz, rs);
    chk("reset result4", rs, 64'd0);

    do_op(1'b0, 1'b0, 32'd7, 32'd2, 1'b0, "u7_2");
    do_op(1'b0, 1'b1, 32'hFFFF_FFF9, 32'd2, 1'b0, "s-7_2");
    do_op(1'b0, 1'b1, 32'd7, 32'hFFFF_FFFE, 1'b0, "s7_-2");
    do_op(1'b0, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, "smin_-1");
    do_op(1'b0, 1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, "umin_-1");
    do_op(1'b0, 1'b0, 32'd5, 32'd0, 1'b0, "u5_0");
    do_op(1'b0, 1'b1, 32'd5, 32'd0, 1'b0, "s5_0");
    do_op(1'b0, 1'b0, 32'd100, 32'd7, 1'b0, "after_zero");
    do_op(1'b0, 1'b0, 32'hFFFF_FFFF, 32'd1, 1'b0, "umax_1");
    do_op(1'b0, 1'b0, 32'd1000, 32'd3, 1'b1, "repulse");

    // abort in the middle of RUN
    @(negedge clk);
    set_in(1'b0, 1'b1, 1'b0, 32'd1000, 32'd3);
    @(negedge clk);
    set_in(1'b0, 1'b0, 1'b0, 32'd1000, 32'd3);
    repeat (9) @(negedge clk);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    get_out(1'b0, bz, dn, dz, rs);
    chk("abort busy", 64'(bz), 64'd0);
    chk("abort result", rs, 64'd0);
    chk("abort dz", 64'(dz), 64'd0);
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done0) seen = 1'b1;
    end
    chk("abort no_done", 64'(seen), 64'd0);
    do_op(1'b0, 1'b0, 32'd1000, 32'd3, 1'b0, "after_abort");

    do_op(1'b1, 1'b0, 32'd100, 32'd7, 1'b0, "s4_100_7");
    do_op(1'b1, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, "s4_min_-1");
    do_op(1'b1, 1'b0, 32'd5, 32'd0, 1'b0, "s4_5_0");

    for (int i = 0; i < 30; i++) begin
      ra  = $urandom;
      rb  = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(1, 20)) : $urandom;
      rsg = 1'($urandom_range(0, 1));
      do_op(1'((i % 2)), rsg, ra, rb, 1'b0, "rand");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
